// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the RAM arbiter/sequencer slice.
package ram_arbiter_pkg;

    localparam int NUM_REQ    = 2;
    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_RDWAIT = 3'd2,
        ST_RESP   = 3'd3,
        ST_CLEAR  = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational one-hot grant from the
// request vector and a registered last-served pointer.
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_update,
    output logic [NUM_REQ-1:0] o_gnt
);

    // 1 means requester 1 was served last, so requester 0 wins the next tie
    logic last_reg;

    // On a tie favour the requester that was not served last
    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = last_reg ? 2'b01 : 2'b10;
        end
    end

    // Remember who was served, only when a grant is actually taken
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_reg <= 1'b1;
        end else if (i_update) begin
            last_reg <= o_gnt[1];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer in front of a single-port synchronous
// RAM with a one-cycle registered read. Also performs a zero-fill sweep.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [1:0]         i_req,
    input  logic [1:0]         i_we,
    input  logic [ADDR_W-1:0]  i_addr0,
    input  logic [ADDR_W-1:0]  i_addr1,
    input  logic [DATA_W-1:0]  i_wdata0,
    input  logic [DATA_W-1:0]  i_wdata1,
    input  logic               i_clr,
    output logic [1:0]         o_gnt,
    output logic               o_done,
    output logic [DATA_W-1:0]  o_rdata,
    output logic               o_busy,
    output logic               o_clr_done,
    output logic               o_ram_we,
    output logic [ADDR_W-1:0]  o_ram_addr,
    output logic [DATA_W-1:0]  o_ram_wdata,
    input  logic [DATA_W-1:0]  i_ram_rdata
);

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    state_t              state_reg, state_next;
    logic [1:0]          gnt_reg, gnt_next;
    logic                done_reg, done_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic                busy_reg, busy_next;
    logic                clr_done_reg, clr_done_next;
    logic                ram_we_reg, ram_we_next;
    logic [ADDR_W-1:0]   ram_addr_reg, ram_addr_next;
    logic [DATA_W-1:0]   ram_wdata_reg, ram_wdata_next;
    logic                clr_pend_reg, clr_pend_next;
    logic [ADDR_W-1:0]   cnt_reg, cnt_next;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic                arb_update;
    logic                sel;

    logic [ADDR_W-1:0]   req_addr  [NUM_REQ];
    logic [DATA_W-1:0]   req_wdata [NUM_REQ];

    // Per-requester address/data gathered into arrays indexed by requester
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_addr[gi]  = (gi == 0) ? i_addr0  : i_addr1;
            assign req_wdata[gi] = (gi == 0) ? i_wdata0 : i_wdata1;
        end
    endgenerate

    rr_arb2 u_arb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req    (i_req),
        .i_update (arb_update),
        .o_gnt    (arb_gnt)
    );

    assign sel = arb_gnt[1];

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        rdata_next     = rdata_reg;
        ram_we_next    = ram_we_reg;
        ram_addr_next  = ram_addr_reg;
        ram_wdata_next = ram_wdata_reg;
        clr_pend_next  = clr_pend_reg | i_clr;
        cnt_next       = cnt_reg;
        clr_done_next  = 1'b0;
        arb_update     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (clr_pend_reg || i_clr) begin
                    // Sweep takes priority over any waiting request
                    cnt_next       = '0;
                    ram_we_next    = 1'b1;
                    ram_addr_next  = '0;
                    ram_wdata_next = '0;
                    clr_pend_next  = 1'b0;
                    state_next     = ST_CLEAR;
                end else if (|i_req) begin
                    arb_update     = 1'b1;
                    gnt_next       = arb_gnt;
                    ram_we_next    = i_we[sel];
                    ram_addr_next  = req_addr[sel];
                    ram_wdata_next = req_wdata[sel];
                    state_next     = ST_ACCESS;
                end else begin
                    ram_we_next = 1'b0;
                end
            end
            ST_ACCESS: begin
                // RAM samples the port at the end of this cycle
                if (ram_we_reg) begin
                    ram_we_next = 1'b0;
                    state_next  = ST_RESP;
                end else begin
                    state_next  = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                rdata_next = i_ram_rdata;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                gnt_next   = '0;
                state_next = ST_IDLE;
            end
            ST_CLEAR: begin
                if (cnt_reg == CNT_LAST) begin
                    ram_we_next   = 1'b0;
                    clr_done_next = 1'b1;
                    state_next    = ST_IDLE;
                end else begin
                    cnt_next      = cnt_reg + 1'b1;
                    ram_addr_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        done_next = (state_next == ST_RESP);
        busy_next = (state_next != ST_IDLE);
    end

    // State and output registers, cleared immediately by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= ST_IDLE;
            gnt_reg       <= '0;
            done_reg      <= 1'b0;
            rdata_reg     <= '0;
            busy_reg      <= 1'b0;
            clr_done_reg  <= 1'b0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            clr_pend_reg  <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            done_reg      <= done_next;
            rdata_reg     <= rdata_next;
            busy_reg      <= busy_next;
            clr_done_reg  <= clr_done_next;
            ram_we_reg    <= ram_we_next;
            ram_addr_reg  <= ram_addr_next;
            ram_wdata_reg <= ram_wdata_next;
            clr_pend_reg  <= clr_pend_next;
            cnt_reg       <= cnt_next;
        end
    end

    assign o_gnt       = gnt_reg;
    assign o_done      = done_reg;
    assign o_rdata     = rdata_reg;
    assign o_busy      = busy_reg;
    assign o_clr_done  = clr_done_reg;
    assign o_ram_we    = ram_we_reg;
    assign o_ram_addr  = ram_addr_reg;
    assign o_ram_wdata = ram_wdata_reg;

endmodule
